// File: rtl/store_unit.sv
// Read-modify-write store sequencer: merges a byte/halfword/word register value into a memory word.
// Optional macro STORE_WORD_BYPASS_EN lets word stores skip the read phase.
module store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  StoreControl,
    input  logic [31:0] addr,
    input  logic [31:0] RegData,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT     = 3'(MEM_LATENCY);
    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;

    // Keep the memory bits outside the store size, replace the rest with the register value.
    function automatic logic [31:0] merge_word(input logic [1:0]  size,
                                               input logic [31:0] m,
                                               input logic [31:0] r);
        logic [31:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (m & ~mask) | (r & mask);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        data_d      = data_q;
        size_d      = size_q;

        case (state_q)
            IDLE: begin
                if (start && (StoreControl != SZ_NONE)) begin
                    data_d     = RegData;
                    size_d     = StoreControl;
                    mem_addr_d = addr;
                    busy_d     = 1'b1;
`ifdef STORE_WORD_BYPASS_EN
                    if (StoreControl == SZ_WORD) begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = RegData;
                    end else begin
                        state_d  = READ;
                        cnt_d    = LAT;
                        mem_rd_d = 1'b1;
                    end
`else
                    state_d  = READ;
                    cnt_d    = LAT;
                    mem_rd_d = 1'b1;
`endif
                end
            end
            READ: begin
                // Counter reaching zero marks the cycle in which read data is valid.
                if (cnt_q == 3'd0) begin
                    mem_wdata_d = merge_word(size_q, mem_rdata, data_q);
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b1;
                    state_d     = WRITE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE: begin
                mem_wr_d = 1'b0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Request payload is only meaningful after an accept, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        size_q <= size_d;
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
